// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame levels, baud divisor helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Receiver/transmitter frame-walk states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Line levels that delimit a frame
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // System clocks spent on one bit period at the given line rate
    function automatic int clks_per_bit(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Restartable bit-period counter; phase is set by the FSM clearing it on state entry.
// Latency: tick is combinational from the count, asserted when count == target.
// Backpressure: none; counter wraps to 0 on tick or clear.
module uart_bit_timer #(
    parameter int MAX = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [$clog2(MAX)-1:0] target,
    output logic                   tick
);

    logic [$clog2(MAX)-1:0] r_count;

    assign tick = (r_count == target);

    // Count up from 0, restarting on clear or when the target is reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Serial receiver: 1 start, DATA_WIDTH data bits LSB-first, 1 stop, no parity.
// Latency: valid/frame_error pulse ~2 + HALF_BIT + 9*CLKS_PER_BIT clk after start edge.
// Backpressure: none; each valid overwrites received_data, consumer captures on strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TMR_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_WIDTH + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [TMR_W-1:0] T_HALF   = TMR_W'(HALF_BIT - 1);
    localparam logic [TMR_W-1:0] T_FULL   = TMR_W'(CLKS_PER_BIT - 1);

    // Line conditioning
    logic r_sync1;
    logic r_line_s;
    logic r_line_d;

    // FSM and datapath state
    uart_state_t           r_state;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_ferr;

    // Combinational controls
    uart_state_t      w_state_nxt;
    logic             w_fall;
    logic             w_tick;
    logic             w_clear;
    logic [TMR_W-1:0] w_target;
    logic             w_sample;
    logic             w_valid_nxt;
    logic             w_ferr_nxt;

    assign w_fall   = r_line_d && !r_line_s;
    assign w_target = (r_state == START) ? T_HALF : T_FULL;
    // Hold the timer at 0 while idle and restart it on every state change so
    // sampling points are phased from the detected start edge.
    assign w_clear  = (r_state == IDLE) || (w_state_nxt != r_state);

    uart_bit_timer #(
        .MAX (CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .target (w_target),
        .tick   (w_tick)
    );

    // Two-flop synchronizer plus one delay flop for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= IDLE_LEVEL;
            r_line_s <= IDLE_LEVEL;
            r_line_d <= IDLE_LEVEL;
        end else begin
            r_sync1  <= line;
            r_line_s <= r_sync1;
            r_line_d <= r_line_s;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode; STOP exits at mid stop bit to catch back-to-back frames
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_tick) begin
                    // A start bit that is no longer low at mid-bit was a glitch
                    w_state_nxt = (r_line_s == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_sample = 1'b1;
                    if (r_bit_idx == LAST_IDX) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    if (r_line_s == STOP_BIT) begin
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bit index and shift register capture at each data mid-bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == START) begin
                r_bit_idx <= '0;
            end else if (w_sample) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (w_sample && (r_bit_idx == IDX_W'(i))) begin
                    r_shift[i] <= r_line_s;
                end
            end
        end
    end

    // Registered outputs: word update and one-cycle strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            if (w_valid_nxt) begin
                r_data <= r_shift;
            end
        end
    end

    assign received_data = r_data;
    assign valid         = r_valid;
    assign frame_error   = r_ferr;
    assign busy          = (r_state != IDLE);

endmodule
